lcd_byte_sequencer: RTL and testbench

- Hardware sequencer for the Spartan-3E character LCD in 4-bit mode.
- Replaces the firmware STO/SHL/LCD/NOP sequences: the CPU hands over one byte per command, and the block produces both nibble strobes and all inter-command waits.
- Optionally runs the power-on init sequence itself.
- Sits between the CPU's LCD instruction path and the LCD pins (SF_D[11:8], LCD_E, LCD_RS, LCD_RW).

---
 rtl/lcd_pkg.sv | 39 +++
 rtl/lcd_nibble_strobe.sv | 80 ++++++++
 rtl/lcd_byte_sequencer.sv | 176 +++++++++++++++++
 tb/tb_lcd_byte_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared state encoding, default timing and command constants for the
// Spartan-3E character LCD sequencer.
package lcd_pkg;

  typedef enum logic [3:0] {
    PWR_WAIT,
    INIT_NIB,
    INIT_WAIT,
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    GAP,
    WAIT
  } state_t;

  localparam int DEF_T_POWERUP = 750000;
  localparam int DEF_T_INIT1   = 205000;
  localparam int DEF_T_INIT2   = 5000;
  localparam int DEF_T_SHORT   = 2000;
  localparam int DEF_T_CLEAR   = 82000;
  localparam int DEF_T_NIBBLE  = 50;
  localparam int DEF_T_SETUP   = 2;
  localparam int DEF_T_EPULSE  = 12;
  localparam int DEF_T_HOLD    = 1;
  localparam int DEF_CW        = 20;

  localparam logic [3:0] NIB_INIT_3 = 4'h3;
  localparam logic [3:0] NIB_INIT_2 = 4'h2;

  localparam logic [7:0] OP_CLEAR = 8'h01;
  localparam logic [7:0] OP_HOME  = 8'h02;

  // Return Home ignores its LSB, so 0x03 is a home command as well.
  function automatic logic needs_long_wait(input logic rs, input logic [7:0] cmd);
    return !rs && (cmd == OP_CLEAR || cmd == OP_HOME || cmd == 8'h03);
  endfunction

endpackage

// File: rtl/lcd_nibble_strobe.sv
// One LCD nibble write: SETUP (D/RS stable, E low), PULSE (E high), HOLD.
// Holds the last nibble and RS on its outputs between writes.
module lcd_nibble_strobe
  import lcd_pkg::*;
#(
  parameter int CW       = DEF_CW,
  parameter int T_SETUP  = DEF_T_SETUP,
  parameter int T_EPULSE = DEF_T_EPULSE,
  parameter int T_HOLD   = DEF_T_HOLD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] nibble,
  input  logic       rs,
  output logic       done,
  output logic [3:0] lcd_d,
  output logic       lcd_e,
  output logic       lcd_rs
);

  state_t          phase, phase_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [3:0]      d_q, d_next;
  logic            rs_q, rs_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= IDLE;
      cnt   <= '0;
      d_q   <= '0;
      rs_q  <= 1'b0;
    end else begin
      phase <= phase_next;
      cnt   <= cnt_next;
      d_q   <= d_next;
      rs_q  <= rs_next;
    end
  end

  always_comb begin
    phase_next = phase;
    cnt_next   = (cnt != '0) ? cnt - CW'(1) : cnt;
    d_next     = d_q;
    rs_next    = rs_q;
    case (phase)
      IDLE: begin
        if (start) begin
          phase_next = SETUP;
          cnt_next   = CW'(T_SETUP - 1);
          d_next     = nibble;
          rs_next    = rs;
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          phase_next = PULSE;
          cnt_next   = CW'(T_EPULSE - 1);
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          phase_next = HOLD;
          cnt_next   = CW'(T_HOLD - 1);
        end
      end
      HOLD: begin
        if (cnt == '0) phase_next = IDLE;
      end
      default: phase_next = IDLE;
    endcase
  end

  // E comes straight from the phase register so an async reset drops it at once.
  assign done   = (phase == HOLD) && (cnt == '0);
  assign lcd_e  = (phase == PULSE);
  assign lcd_d  = d_q;
  assign lcd_rs = rs_q;

endmodule

// File: rtl/lcd_byte_sequencer.sv
// Byte-level LCD sequencer: splits each byte into two nibble strobes and
// inserts the command wait. LCD_INIT_SEQ_EN enables the built-in power-on init.
module lcd_byte_sequencer
  import lcd_pkg::*;
#(
  parameter int T_POWERUP = DEF_T_POWERUP,
  parameter int T_INIT1   = DEF_T_INIT1,
  parameter int T_INIT2   = DEF_T_INIT2,
  parameter int T_SHORT   = DEF_T_SHORT,
  parameter int T_CLEAR   = DEF_T_CLEAR,
  parameter int T_NIBBLE  = DEF_T_NIBBLE,
  parameter int T_SETUP   = DEF_T_SETUP,
  parameter int T_EPULSE  = DEF_T_EPULSE,
  parameter int T_HOLD    = DEF_T_HOLD,
  parameter int CW        = DEF_CW
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iValid,
  input  logic       iRS,
  input  logic [7:0] iData,
  output logic       oReady,
  output logic       oInitDone,
  output logic [3:0] oLCD_D,
  output logic       oLCD_E,
  output logic       oLCD_RS,
  output logic       oLCD_RW
);

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          lo_q, lo_next;
  logic [7:0]    byte_q, byte_next;
  logic          rs_q, rs_next;
  logic [1:0]    idx_q, idx_next;
  logic          init_done, init_done_next;
  logic          strobe_start, strobe_done, strobe_rs;
  logic [3:0]    strobe_nib;

  function automatic logic [CW-1:0] init_wait_load(input logic [1:0] idx);
    case (idx)
      2'd0:    return CW'(T_INIT1 - 1);
      2'd1:    return CW'(T_INIT2 - 1);
      default: return CW'(T_SHORT - 1);
    endcase
  endfunction

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
`ifdef LCD_INIT_SEQ_EN
      state <= PWR_WAIT;
`else
      state <= IDLE;
`endif
      cnt       <= CW'(T_POWERUP - 1);
      lo_q      <= 1'b0;
      byte_q    <= '0;
      rs_q      <= 1'b0;
      idx_q     <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      lo_q      <= lo_next;
      byte_q    <= byte_next;
      rs_q      <= rs_next;
      idx_q     <= idx_next;
      init_done <= init_done_next;
    end
  end

  // INIT_NIB and SETUP cover a whole nibble strobe; the sub-module owns its phases.
  always_comb begin
    state_next = state;
    cnt_next   = (cnt != '0) ? cnt - CW'(1) : cnt;
    lo_next    = lo_q;
    byte_next  = byte_q;
    rs_next    = rs_q;
    idx_next   = idx_q;
`ifdef LCD_INIT_SEQ_EN
    init_done_next = init_done;
`else
    init_done_next = 1'b1;
`endif
    strobe_start = 1'b0;
    strobe_nib   = lo_q ? byte_q[3:0] : byte_q[7:4];
    strobe_rs    = rs_q;
    case (state)
      PWR_WAIT: begin
        if (cnt == '0) begin
          strobe_start = 1'b1;
          strobe_nib   = NIB_INIT_3;
          strobe_rs    = 1'b0;
          idx_next     = 2'd0;
          state_next   = INIT_NIB;
        end
      end
      INIT_NIB: begin
        if (strobe_done) begin
          state_next = INIT_WAIT;
          cnt_next   = init_wait_load(idx_q);
        end
      end
      INIT_WAIT: begin
        if (cnt == '0) begin
          if (idx_q == 2'd3) begin
            state_next     = IDLE;
            init_done_next = 1'b1;
          end else begin
            idx_next     = idx_q + 2'd1;
            strobe_start = 1'b1;
            strobe_nib   = (idx_q == 2'd2) ? NIB_INIT_2 : NIB_INIT_3;
            strobe_rs    = 1'b0;
            state_next   = INIT_NIB;
          end
        end
      end
      IDLE: begin
        if (iValid && init_done) begin
          byte_next    = iData;
          rs_next      = iRS;
          lo_next      = 1'b0;
          strobe_start = 1'b1;
          strobe_nib   = iData[7:4];
          strobe_rs    = iRS;
          state_next   = SETUP;
        end
      end
      SETUP: begin
        if (strobe_done) begin
          if (!lo_q) begin
            state_next = GAP;
            cnt_next   = CW'(T_NIBBLE - 1);
          end else begin
            state_next = WAIT;
            cnt_next   = needs_long_wait(rs_q, byte_q) ? CW'(T_CLEAR - 1) : CW'(T_SHORT - 1);
          end
        end
      end
      GAP: begin
        if (cnt == '0) begin
          lo_next      = 1'b1;
          strobe_start = 1'b1;
          strobe_nib   = byte_q[3:0];
          state_next   = SETUP;
        end
      end
      WAIT: begin
        if (cnt == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  lcd_nibble_strobe #(
    .CW      (CW),
    .T_SETUP (T_SETUP),
    .T_EPULSE(T_EPULSE),
    .T_HOLD  (T_HOLD)
  ) u_strobe (
    .clk   (Clock),
    .rst_n (Reset),
    .start (strobe_start),
    .nibble(strobe_nib),
    .rs    (strobe_rs),
    .done  (strobe_done),
    .lcd_d (oLCD_D),
    .lcd_e (oLCD_E),
    .lcd_rs(oLCD_RS)
  );

  assign oReady    = (state == IDLE) && init_done;
  assign oInitDone = init_done;
  assign oLCD_RW   = 1'b0;

endmodule

// File: tb/tb_lcd_byte_sequencer.sv
// Bench for lcd_byte_sequencer with shortened waits; a schedule-based model of
// strobe windows and busy periods is compared against the pins every cycle.
module tb_lcd_byte_sequencer;

  localparam int P_POWERUP = 100;
  localparam int P_INIT1   = 300;
  localparam int P_INIT2   = 150;
  localparam int P_SHORT   = 60;
  localparam int P_CLEAR   = 500;
  localparam int P_NIBBLE  = 50;
  localparam int P_SETUP   = 2;
  localparam int P_EPULSE  = 12;
  localparam int P_HOLD    = 1;
  localparam int STROBE    = P_SETUP + P_EPULSE + P_HOLD;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       ivalid = 1'b0;
  logic       irs = 1'b0;
  logic [7:0] idata = 8'h00;
  logic       o_ready, o_init_done, o_e, o_rs, o_rw;
  logic [3:0] o_d;

  int n_checks = 0;
  int n_fail = 0;

  int cyc = 0;
  int busy_until = 0;
  int init_idle = 0;
  int model_t = 0;
  int model_k = 0;
  int       s_setup[$];
  logic [3:0] s_nib[$];
  logic       s_rs[$];

  lcd_byte_sequencer #(
    .T_POWERUP(P_POWERUP), .T_INIT1(P_INIT1), .T_INIT2(P_INIT2),
    .T_SHORT(P_SHORT), .T_CLEAR(P_CLEAR), .T_NIBBLE(P_NIBBLE),
    .T_SETUP(P_SETUP), .T_EPULSE(P_EPULSE), .T_HOLD(P_HOLD), .CW(20)
  ) dut (
    .Clock(clock), .Reset(reset_n), .iValid(ivalid), .iRS(irs), .iData(idata),
    .oReady(o_ready), .oInitDone(o_init_done), .oLCD_D(o_d), .oLCD_E(o_e),
    .oLCD_RS(o_rs), .oLCD_RW(o_rw)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic push_strobe(input int at, input logic [3:0] nib, input logic rs);
    s_setup.push_back(at);
    s_nib.push_back(nib);
    s_rs.push_back(rs);
  endtask

  // Model: cycle count since reset release, scheduled strobe windows, busy-until time.
  always begin
    @(posedge clock or negedge reset_n);
    if (!reset_n) begin
      cyc = 0;
      s_setup.delete();
      s_nib.delete();
      s_rs.delete();
`ifdef LCD_INIT_SEQ_EN
      model_t = P_POWERUP;
      push_strobe(model_t, 4'h3, 1'b0);
      model_t += STROBE + P_INIT1;
      push_strobe(model_t, 4'h3, 1'b0);
      model_t += STROBE + P_INIT2;
      push_strobe(model_t, 4'h3, 1'b0);
      model_t += STROBE + P_SHORT;
      push_strobe(model_t, 4'h2, 1'b0);
      model_t += STROBE + P_SHORT;
      init_idle = model_t;
`else
      init_idle = 1;
`endif
      busy_until = init_idle;
    end else begin
      model_k = cyc + 1;
      if (ivalid && cyc >= busy_until) begin
        push_strobe(model_k, idata[7:4], irs);
        push_strobe(model_k + STROBE + P_NIBBLE, idata[3:0], irs);
        busy_until = model_k + 2 * STROBE + P_NIBBLE +
                     ((!irs && idata >= 8'h01 && idata <= 8'h03) ? P_CLEAR : P_SHORT);
      end
      cyc = model_k;
    end
  end

  always begin
    logic       e_exp, rs_exp;
    logic [3:0] d_exp;
    @(negedge clock);
    if (!reset_n) begin
      checkOutput("rst_e", o_e, 0);
      checkOutput("rst_d", o_d, 0);
      checkOutput("rst_rs", o_rs, 0);
      checkOutput("rst_ready", o_ready, 0);
      checkOutput("rst_initdone", o_init_done, 0);
      checkOutput("rst_rw", o_rw, 0);
    end else begin
      e_exp = 1'b0;
      d_exp = 4'h0;
      rs_exp = 1'b0;
      for (int i = 0; i < s_setup.size(); i++) begin
        if (s_setup[i] <= cyc) begin
          d_exp = s_nib[i];
          rs_exp = s_rs[i];
          if (cyc >= s_setup[i] + P_SETUP && cyc < s_setup[i] + P_SETUP + P_EPULSE) e_exp = 1'b1;
        end
      end
      checkOutput("cmp_e", o_e, e_exp);
      checkOutput("cmp_d", o_d, d_exp);
      checkOutput("cmp_rs", o_rs, rs_exp);
      checkOutput("cmp_ready", o_ready, cyc >= busy_until);
      checkOutput("cmp_initdone", o_init_done, cyc >= init_idle);
      checkOutput("cmp_rw", o_rw, 0);
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (o_ready !== 1'b1 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    checkOutput("ready_timeout", o_ready, 1);
  endtask

  task automatic wait_e_rise(output int at);
    int n = 0;
    while (o_e === 1'b1 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    while (o_e !== 1'b1 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    checkOutput("e_rise_timeout", o_e, 1);
    at = cyc;
  endtask

  task automatic applyStimulus(input logic rs, input logic [7:0] data, output int k);
    wait_ready();
    ivalid = 1'b1;
    irs = rs;
    idata = data;
    @(posedge clock);
    #1;
    k = cyc;
    ivalid = 1'b0;
    irs = ~rs;
    idata = 8'hFF;
    @(negedge clock);
  endtask

  task automatic run_byte(input logic rs, input logic [7:0] data, input int exp_lat, input string name);
    int k, r1, r2;
    applyStimulus(rs, data, k);
    wait_e_rise(r1);
    checkOutput({name, "_hi_rise"}, r1 - k, 2);
    wait_e_rise(r2);
    checkOutput({name, "_lo_rise"}, r2 - r1, 65);
    wait_ready();
    checkOutput({name, "_latency"}, cyc - k, exp_lat);
  endtask

  task automatic check_init_sequence();
`ifdef LCD_INIT_SEQ_EN
    int r0, r1, r2, r3;
    wait_e_rise(r0);
    checkOutput("init_rise0", r0, 102);
    checkOutput("init_d0", o_d, 3);
    wait_e_rise(r1);
    checkOutput("init_gap1", r1 - r0, 315);
    wait_e_rise(r2);
    checkOutput("init_gap2", r2 - r1, 165);
    wait_e_rise(r3);
    checkOutput("init_gap3", r3 - r2, 75);
    checkOutput("init_d3", o_d, 2);
    wait_ready();
    checkOutput("init_done_cycle", cyc, 730);
    checkOutput("init_done_flag", o_init_done, 1);
`else
    @(negedge clock);
    checkOutput("nf_first_cycle", cyc, 1);
    checkOutput("nf_ready", o_ready, 1);
    checkOutput("nf_initdone", o_init_done, 1);
`endif
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k, k2, r, n;
    repeat (3) @(negedge clock);
    checkOutput("reset_ready", o_ready, 0);
    checkOutput("reset_e", o_e, 0);
    reset_n = 1'b1;
    check_init_sequence();

    $display("[TB] byte writes");
    run_byte(1'b1, 8'h48, 140, "data_H");
    run_byte(1'b0, 8'h01, 580, "clear");
    run_byte(1'b0, 8'h28, 140, "func_set");
    run_byte(1'b0, 8'h03, 580, "home3");
    run_byte(1'b1, 8'h01, 140, "data01");
    run_byte(1'b0, 8'h04, 140, "entry04");

    $display("[TB] valid held through busy period");
    wait_ready();
    ivalid = 1'b1;
    irs = 1'b1;
    idata = 8'h41;
    @(posedge clock);
    #1;
    k = cyc;
    @(negedge clock);
    n = 0;
    while (o_ready !== 1'b1 && n < 2000) begin
      idata = idata + 8'h01;
      @(negedge clock);
      n++;
    end
    checkOutput("busy_ready_at", cyc - k, 140);
    idata = 8'h5A;
    @(posedge clock);
    #1;
    k2 = cyc;
    ivalid = 1'b0;
    @(negedge clock);
    checkOutput("busy_second_accept", k2 - k, 141);
    wait_e_rise(r);
    checkOutput("busy_second_nib", o_d, 5);
    wait_ready();

    $display("[TB] reset during E pulse");
    applyStimulus(1'b1, 8'h33, k);
    wait_e_rise(r);
    repeat (3) @(negedge clock);
    checkOutput("pre_reset_e", o_e, 1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("reset_e_async", o_e, 0);
    checkOutput("reset_ready_async", o_ready, 0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    check_init_sequence();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
